// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller and its lane logic.
// funct3 codes, FSM encoding, access width classification.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2,
        W_BAD  = 2'd3
    } width_t;

    // Unsigned variants only make sense for loads; a store with them is illegal.
    function automatic width_t f3_width(input logic [2:0] f3, input logic is_store);
        width_t w;
        case (f3)
            F3_B:    w = W_BYTE;
            F3_H:    w = W_HALF;
            F3_W:    w = W_WORD;
            F3_BU:   w = is_store ? W_BAD : W_BYTE;
            F3_HU:   w = is_store ? W_BAD : W_HALF;
            default: w = W_BAD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Lane steering: byte enables, store replication, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when results are used.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic        illegal,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data
);

    width_t      width;
    logic [31:0] shifted;

    always_comb begin
        width      = f3_width(funct3, is_store);
        illegal    = (width == W_BAD);
        misaligned = 1'b0;
        be         = 4'b0000;
        wdata_rep  = wdata;
        case (width)
            W_BYTE: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            W_HALF: begin
                misaligned = offset[0];
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
            end
            W_WORD: begin
                misaligned = |offset;
                be         = 4'b1111;
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend per funct3.
    always_comb begin
        shifted = mem_rdata >> {ld_offset, 3'b000};
        ld_data = mem_rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {24'b0, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {16'b0, shifted[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns load/store strobes into a req/ack bus access.
// Latency: 3 cycles minimum (IDLE, REQ, DONE); REQ extends until ack or TIMEOUT cycles.
// Backpressure: stall holds the core while waiting on mem_ack; timeout aborts with bus_err.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t        state;
    logic [TW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          err_q;

    logic          access;
    logic          idle_acc;
    logic          req_illegal;
    logic          req_misal;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic [31:0]   ld_data;

    assign access   = memread | memwrite;
    assign idle_acc = (state == IDLE) && access;

    // Load side is driven from registered funct3/offset so it stays valid through REQ.
    dmem_lane u_lane (
        .funct3     (funct3),
        .is_store   (memwrite),
        .offset     (addr[1:0]),
        .wdata      (wdata),
        .illegal    (req_illegal),
        .misaligned (req_misal),
        .be         (be_n),
        .wdata_rep  (wdata_n),
        .ld_funct3  (f3_q),
        .ld_offset  (off_q),
        .mem_rdata  (mem_rdata),
        .ld_data    (ld_data)
    );

    assign misaligned = idle_acc && req_misal;
    assign stall      = (state == REQ) || (idle_acc && !req_misal);
    assign bus_err    = (state == DONE) && err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    err_q <= 1'b0;
                    if (access && !req_misal) begin
                        if (req_illegal) begin
                            err_q <= 1'b1;
                            rdata <= '0;
                            state <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= memwrite;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_n;
                            mem_wdata <= wdata_n;
                            f3_q      <= funct3;
                            off_q     <= addr[1:0];
                            cnt       <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata   <= mem_we ? 32'b0 : ld_data;
                        state   <= DONE;
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        mem_req <= 1'b0;
                        err_q   <= 1'b1;
                        rdata   <= '0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized accesses against a reference model.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset, memread, memwrite, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        stall, misaligned, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .misaligned(misaligned), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Observations from one access, filled by run_access.
    int          o_stall, o_req;
    logic        o_mis, o_err, o_err_early, o_stable, o_req_done, o_hang, o_we;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_be;

    // ---------------- reference model ----------------
    function automatic logic m_legal(input logic wr, input logic [2:0] f3);
        if (wr) return (f3 <= 3'd2);
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] t;
        t = ((8'd1 << m_size(f3)) - 8'd1) << a[1:0];
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        logic [63:0] v, mask;
        int sz = m_size(f3);
        v = {32'b0, word} >> (8 * a[1:0]);
        if (sz < 4) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            v = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        return v[31:0];
    endfunction

    // ---------------- driver / bus responder ----------------
    // ack_at: REQ cycle (1-based) in which mem_ack is returned; 0 = never.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_at, input logic [31:0] word, input logic noise);
        int cyc = 0;
        o_stall = 0; o_req = 0; o_mis = 0; o_err = 0; o_err_early = 0;
        o_stable = 1; o_req_done = 0; o_hang = 0;
        o_addr = '0; o_be = '0; o_wdata = '0; o_we = 0; o_rdata = '0;
        @(negedge clk);
        memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd; mem_rdata = word;
        forever begin
            #1;
            if (misaligned) o_mis = 1;
            if (mem_req) begin
                o_req++;
                if (o_req == 1) begin
                    o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o_addr, o_be, o_wdata, o_we}) begin
                    o_stable = 0;
                end
                mem_ack = (o_req == ack_at);
            end else begin
                mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (!stall) begin
                o_rdata = rdata; o_err = bus_err; o_req_done = mem_req;
                break;
            end
            o_stall++;
            if (bus_err) o_err_early = 1;
            cyc++;
            if (cyc > 64) begin
                o_hang = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        memread = 0; memwrite = 0; mem_ack = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1; memread = 0; memwrite = 0; mem_ack = 0; funct3 = 0;
        addr = 0; wdata = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({stall, misaligned, bus_err, mem_req, mem_we, mem_be} !== 9'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {stall, misaligned, bus_err, mem_req, mem_we, mem_be});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rdata} !== 96'b0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h expected 0", mem_addr, mem_wdata, rdata);
        end
        reset = 0;
        // ack with no access pending must do nothing
        mem_ack = 1;
        repeat (2) @(negedge clk);
        mem_ack = 0;
        n_checks++;
        if ({stall, mem_req, bus_err} !== 3'b0 || rdata !== 32'b0) begin
            n_fail++; $display("FAIL stray_ack: got stall=%b req=%b err=%b rdata=%h expected 0", stall, mem_req, bus_err, rdata);
        end
    endtask

    task automatic test_lw();
        run_access(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0);
        n_checks++;
        if (o_stall !== 2 || o_req !== 1) begin
            n_fail++; $display("FAIL lw_latency: got stall=%0d req=%0d expected 2 1", o_stall, o_req);
        end
        n_checks++;
        if (o_be !== 4'b1111 || o_addr !== 32'h100 || o_we !== 1'b0) begin
            n_fail++; $display("FAIL lw_bus: got be=%b addr=%h we=%b expected 1111 00000100 0", o_be, o_addr, o_we);
        end
        n_checks++;
        if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0 || o_req_done !== 1'b0) begin
            n_fail++; $display("FAIL lw_data: got %h err=%b req=%b expected deadbeef 0 0", o_rdata, o_err, o_req_done);
        end
    endtask

    task automatic test_sh_delay();
        run_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 5, 32'hFFFFFFFF, 0);
        n_checks++;
        if (o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_addr !== 32'h100) begin
            n_fail++; $display("FAIL sh_bus: got we=%b be=%b wd=%h addr=%h expected 1 1100 abcdabcd 00000100", o_we, o_be, o_wdata, o_addr);
        end
        n_checks++;
        if (o_stall !== 6 || o_req !== 5 || o_stable !== 1'b1) begin
            n_fail++; $display("FAIL sh_wait: got stall=%0d req=%0d stable=%b expected 6 5 1", o_stall, o_req, o_stable);
        end
        n_checks++;
        if (o_rdata !== 32'h0) begin
            n_fail++; $display("FAIL sh_rdata: got %h expected 0", o_rdata);
        end
    endtask

    task automatic test_timeout();
        run_access(1, 0, 3'b010, 32'h40, 32'h0, 0, 32'h12345678, 0);
        n_checks++;
        if (o_req !== 16 || o_stall !== 17) begin
            n_fail++; $display("FAIL timeout_len: got req=%0d stall=%0d expected 16 17", o_req, o_stall);
        end
        n_checks++;
        if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_err_early !== 1'b0 || o_req_done !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err: got err=%b rdata=%h early=%b req=%b expected 1 0 0 0", o_err, o_rdata, o_err_early, o_req_done);
        end
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle: got stall=%b err=%b req=%b expected 0 0 0", stall, bus_err, mem_req);
        end
    endtask

    task automatic test_lb_lbu();
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0000, 0);
        n_checks++;
        if (o_be !== 4'b1000 || o_rdata !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb: got be=%b rdata=%h expected 1000 ffffff80", o_be, o_rdata);
        end
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF0000, 0);
        n_checks++;
        if (o_be !== 4'b1000 || o_rdata !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu: got be=%b rdata=%h expected 1000 00000080", o_be, o_rdata);
        end
    endtask

    task automatic test_misaligned_illegal();
        run_access(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h55555555, 0);
        n_checks++;
        if (o_mis !== 1'b1 || o_stall !== 0 || o_req !== 0 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL misaligned: got mis=%b stall=%0d req=%0d err=%b expected 1 0 0 0", o_mis, o_stall, o_req, o_err);
        end
        run_access(0, 1, 3'b011, 32'h200, 32'hCAFEF00D, 1, 32'h0, 0);
        n_checks++;
        if (o_err !== 1'b1 || o_req !== 0 || o_stall !== 1 || o_rdata !== 32'h0 || o_mis !== 1'b0) begin
            n_fail++; $display("FAIL illegal: got err=%b req=%0d stall=%0d rdata=%h mis=%b expected 1 0 1 0 0", o_err, o_req, o_stall, o_rdata, o_mis);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        @(negedge clk);
        memread = 1; memwrite = 0; funct3 = 3'b010; addr = 32'h300; mem_ack = 0;
        for (int i = 0; i < 10 && n < 3; i++) begin
            #1;
            if (mem_req) n++;
            if (n == 3) begin
                reset = 1; memread = 0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (n !== 3) begin
            n_fail++; $display("FAIL reset_mid_reach: got %0d REQ cycles expected 3", n);
        end
        n_checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid: got req=%b stall=%b addr=%h expected 0 0 0", mem_req, stall, mem_addr);
        end
        reset = 0;
        run_access(1, 0, 3'b010, 32'h304, 32'h0, 1, 32'h0BADCAFE, 0);
        n_checks++;
        if (o_stall !== 2 || o_rdata !== 32'h0BADCAFE || o_addr !== 32'h304) begin
            n_fail++; $display("FAIL reset_mid_after: got stall=%0d rdata=%h addr=%h expected 2 0badcafe 00000304", o_stall, o_rdata, o_addr);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic        rd, wr, legal, mis, tmo;
            logic [2:0]  f3;
            logic [31:0] a, wd, word;
            int          op, ack_at, reqc;
            op = $urandom_range(0, 2);
            rd = (op != 1); wr = (op != 0);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom(); wd = $urandom(); word = $urandom();
            ack_at = $urandom_range(0, 8);
            run_access(rd, wr, f3, a, wd, ack_at, word, 1);
            legal = m_legal(wr, f3);
            mis = legal && ((a % m_size(f3)) != 0);
            n_checks++;
            if (o_hang !== 1'b0) begin
                n_fail++; $display("FAIL rnd_hang[%0d]: stall did not drop, got %b expected 0", t, o_hang);
            end
            if (!legal) begin
                n_checks++;
                if (o_err !== 1'b1 || o_req !== 0 || o_stall !== 1 || o_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL rnd_illegal[%0d]: got err=%b req=%0d stall=%0d rdata=%h expected 1 0 1 0", t, o_err, o_req, o_stall, o_rdata);
                end
            end else if (mis) begin
                n_checks++;
                if (o_mis !== 1'b1 || o_req !== 0 || o_stall !== 0) begin
                    n_fail++; $display("FAIL rnd_mis[%0d]: got mis=%b req=%0d stall=%0d expected 1 0 0", t, o_mis, o_req, o_stall);
                end
            end else begin
                tmo  = (ack_at == 0);
                reqc = tmo ? 16 : ack_at;
                n_checks++;
                if (o_req !== reqc || o_stall !== reqc + 1 || o_stable !== 1'b1 || o_err !== tmo) begin
                    n_fail++; $display("FAIL rnd_timing[%0d]: got req=%0d stall=%0d stable=%b err=%b expected %0d %0d 1 %b", t, o_req, o_stall, o_stable, o_err, reqc, reqc + 1, tmo);
                end
                n_checks++;
                if (o_we !== wr || o_addr !== {a[31:2], 2'b00} || o_be !== m_be(f3, a) || (wr && o_wdata !== m_wdata(f3, wd))) begin
                    n_fail++; $display("FAIL rnd_bus[%0d]: got we=%b addr=%h be=%b wd=%h expected %b %h %b %h", t, o_we, o_addr, o_be, o_wdata, wr, {a[31:2], 2'b00}, m_be(f3, a), m_wdata(f3, wd));
                end
                n_checks++;
                if (o_rdata !== ((tmo || wr) ? 32'h0 : m_load(f3, a, word))) begin
                    n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h (f3=%b a=%h word=%h)", t, o_rdata, (tmo || wr) ? 32'h0 : m_load(f3, a, word), f3, a, word);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sh_delay();
        test_lw();
        test_timeout();
        test_lb_lbu();
        test_misaligned_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory access controller for the riscv32i core. It consumes the memread/memwrite strobes and funct3 width from the decode/execute stage and drives a req/ack handshake to data memory. It freezes the core with stall until the access completes, then returns sign- or zero-extended load data. It replaces the assumption that data memory always answers in a single cycle.

Parameters:
TIMEOUT, 16, ack wait limit in cycles before abort (>=2)
TW, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high
memread  in  1  load request from decoder
memwrite  in  1  store request from decoder
funct3  in  3  access width/sign (instr[14:12])
addr  in  32  byte address from ALU
wdata  in  32  store data (rs2), LSB-aligned
stall  out  1  hold PC/pipeline this cycle
rdata  out  32  extended load result, valid in DONE
misaligned  out  1  one-cycle pulse, misaligned access dropped
bus_err  out  1  one-cycle pulse in DONE on timeout or illegal funct3
mem_req  out  1  memory request, registered
mem_we  out  1  1=write, registered
mem_addr  out  32  word address ({addr[31:2],2'b00}), registered
mem_be  out  4  byte enables, registered
mem_wdata  out  32  lane-replicated store data, registered
mem_ack  in  1  memory completion, one cycle
mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset: state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, rdata=0, counter=0; stall/misaligned/bus_err=0.
- States: IDLE, REQ, DONE.
- access = memread|memwrite; if both are high, treat as a write.
- Width from funct3: 000/100 byte, 001/101 half, 010 word. Stores accept only 000/001/010. Any other code is illegal.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE, access, misaligned: misaligned=1 for that cycle (combinational). No bus activity. stall=0. Stay in IDLE.
- IDLE, access, illegal funct3: stall=1. Go to DONE with bus_err latched, rdata=0. No bus activity.
- IDLE, access, legal and aligned: stall=1 (combinational). Register mem_addr, mem_we, mem_be and mem_wdata. Go to REQ with counter=0.
- Byte enables: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
- Store data replication: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- REQ: mem_req=1 and stall=1. All mem_* signals are held stable until ack.
  - On mem_ack: capture the extended load into rdata (stores give rdata=0). Go to DONE.
  - Load extraction: select the lane by the registered byte offset. Sign-extend for 000/001, zero-extend for 100/101.
  - No ack: counter increments. When counter==TIMEOUT-1 without ack, drop mem_req, latch the error, set rdata=0, go to DONE.
- DONE: stall=0 and rdata valid; the core advances on this edge. bus_err=1 this cycle if an error was latched. memread/memwrite are ignored (same instruction). Always go to IDLE.
- mem_req deasserts in the cycle after the ack (registered).
- Minimum access latency: 3 cycles (IDLE, REQ with ack in the first REQ cycle, DONE), i.e. stall high for 2 cycles.
- mem_ack outside REQ is ignored.
- Reset mid-operation (any state) returns to IDLE and clears mem_req immediately on that edge; the in-flight access is abandoned.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2).
  - Width enum.
- One combinational sub-module, dmem_lane: byte-enable generation, store replication, load extraction and extension. The FSM and counter stay in dmem_ctrl.

Test Plan:
- LW at 0x100; memory acks in the first REQ cycle with 0xDEADBEEF → stall high 2 cycles, mem_be=1111, mem_addr=0x100, rdata=0xDEADBEEF in DONE.
- LB at 0x103 with rdata word 0x80FF_0000 → mem_be=1000, rdata=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102 with wdata=0x1234ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD. Ack delayed 5 cycles → stall high 6 cycles, mem_req stable throughout.
- LW at 0x101 → misaligned pulse, stall=0, mem_req never asserted. Store with funct3=011 → bus_err in DONE, no mem_req.
- TIMEOUT=16, never ack → mem_req high exactly 16 cycles, then DONE with bus_err=1 and rdata=0, then IDLE.
- Assert reset on the third REQ cycle → next cycle mem_req=0, state IDLE, stall=0. A following LW completes normally.
